prog_feeder: RTL and testbench
==============================

PROG_FEEDER -- requirements
Module: prog_feeder

Interface
REQ-001 SHALL have parameter INST_W, default 32: instruction word width.
REQ-002 SHALL have parameter DEPTH, default 16: program buffer entries; power of two and at least 2.
REQ-003 SHALL have parameter NOP_PAD, default 4: number of trailing NOP issues after the last program word; 0 is legal.
REQ-004 SHALL have parameter NOP_WORD, default all-zero INST_W: the issued NOP encoding.
REQ-005 SHALL have port clk, input, 1: the single clock; all state changes on the rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port ld_en, input, 1: write ld_data into the buffer.
REQ-008 SHALL have port ld_data, input, INST_W: program word to load.
REQ-009 SHALL have port ld_full, output, 1: buffer holds DEPTH words.
REQ-010 SHALL have port start, input, 1: begin issue.
REQ-011 SHALL have port clr, input, 1: empty the buffer.
REQ-012 SHALL have port stall, input, 1: the processor cannot accept a new instruction this cycle.
REQ-013 SHALL have port halt, input, 1: the processor requests early termination, e.g. a flag register output.
REQ-014 SHALL have port inst, output, INST_W: registered instruction to the processor.
REQ-015 SHALL have port inst_valid, output, 1: inst carries a program word, not padding.
REQ-016 SHALL have port pc_tag, output, clog2(DEPTH): buffer index of the word currently on inst.
REQ-017 SHALL have port count, output, clog2(DEPTH)+1: number of loaded words.
REQ-018 SHALL have port busy, output, 1: state is RUN or PAD.
REQ-019 SHALL have port done, output, 1: state is DONE.

Function
REQ-020 SHALL implement the FSM states IDLE, RUN, PAD and DONE, with a registered state.
REQ-021 SHALL, in IDLE only, on ld_en with count<DEPTH, write ld_data at index count and increment count.
- ld_en while full is ignored and count holds.
- ld_en outside IDLE is ignored.
REQ-022 SHALL assert ld_full combinationally when count==DEPTH.
REQ-023 SHALL, on start in IDLE or DONE with count>0, enter RUN and set the read index to 0.
- start with count==0 is ignored.
- start in RUN or PAD is ignored.
REQ-024 SHALL present buffer word 0 on inst with inst_valid=1 and pc_tag=0 in the first RUN cycle, one cycle after start is sampled.
REQ-025 SHALL, in RUN with stall=0, advance to the next index each cycle; with stall=1, hold inst, inst_valid and pc_tag unchanged.
REQ-026 SHALL, when index count-1 is on inst and stall=0, enter PAD, or DONE if NOP_PAD==0.
REQ-027 SHALL, in PAD, drive inst=NOP_WORD with inst_valid=0.
- Counts NOP_PAD unstalled cycles, then enters DONE.
- stall freezes the pad counter.
REQ-028 SHALL give halt in RUN or PAD priority over stall and advance: enter DONE next cycle.
REQ-029 SHALL, in IDLE and DONE, drive inst=NOP_WORD, inst_valid=0 and pc_tag=0.
REQ-030 SHALL retain buffer contents and count in DONE, so start replays the same program.
REQ-031 SHALL, on clr in IDLE or DONE, set count to 0 and enter IDLE.
- clr is ignored in RUN and PAD.
- clr has priority over start and ld_en in the same cycle.
REQ-032 SHALL keep all index and pad counters from wrapping: index stops at count-1 and the pad counter stops at NOP_PAD.

Reset
REQ-033 SHALL, on rst low, asynchronously force state=IDLE, count=0, inst=NOP_WORD, inst_valid=0, pc_tag=0, busy=0, done=0 and ld_full=0.
REQ-034 SHALL not reset buffer contents; they are unreachable because count=0.
REQ-035 SHALL abort any issue in progress when reset asserts mid-RUN, with no further instructions issued.

Structure
REQ-036 SHALL place the state enum (IDLE, RUN, PAD, DONE) and the default NOP constant in the shared package prog_feeder_pkg.
REQ-037 SHALL instantiate one sub-module, prog_ram: a DEPTH x INST_W array with a synchronous write port and an asynchronous read port.
REQ-038 SHALL register the inst output in prog_feeder itself.

Verification
REQ-039 SHALL cover: load 0x80800190, 0x8100012C, 0x0989_0000, start, no stall -> inst sequence 0x80800190, 0x8100012C, 0x09890000 on cycles 1-3 with pc_tag 0-2, then 4 cycles of 0x0 with inst_valid=0, then done=1.
REQ-040 SHALL cover: same program with stall high for 2 cycles while pc_tag=1 -> 0x8100012C is held for 3 cycles and done asserts 2 cycles later than in the unstalled case.
REQ-041 SHALL cover: 17 ld_en writes with DEPTH=16 -> count=16, ld_full=1, and the 17th word is never issued.
REQ-042 SHALL cover: halt asserted while pc_tag=1 during a 5-word program -> next cycle done=1, inst=0x0, and PAD is skipped.
REQ-043 SHALL cover: rst driven low mid-RUN -> outputs reach reset values immediately, count=0, and a subsequent start is ignored.
REQ-044 SHALL cover: in DONE, start replays from pc_tag=0; then clr followed by start in the same cycle -> IDLE, count=0, no issue.

Source files
------------

// File: rtl/prog_feeder_pkg.sv
// Shared types and constants for the program feeder: issue FSM states and the default NOP.
package prog_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PAD  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/prog_ram.sv
// Program buffer: synchronous write port, asynchronous read port, contents not reset.
module prog_ram #(
    parameter int unsigned INST_W = 32,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [INST_W-1:0]          wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [INST_W-1:0]          rdata
);

    logic [INST_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_feeder.sv
// Loads a short program into a buffer and issues it word by word to a processor,
// honouring stall/halt, followed by a run of NOP padding.
module prog_feeder
    import prog_feeder_pkg::*;
#(
    parameter int unsigned       INST_W   = 32,
    parameter int unsigned       DEPTH    = 16,
    parameter int unsigned       NOP_PAD  = 4,
    parameter logic [INST_W-1:0] NOP_WORD = INST_W'(NOP_DEFAULT)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ld_en,
    input  logic [INST_W-1:0]          ld_data,
    output logic                       ld_full,
    input  logic                       start,
    input  logic                       clr,
    input  logic                       stall,
    input  logic                       halt,
    output logic [INST_W-1:0]          inst,
    output logic                       inst_valid,
    output logic [$clog2(DEPTH)-1:0]   pc_tag,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned PW = (NOP_PAD < 2) ? 1 : $clog2(NOP_PAD + 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     count_d;
    logic [AW-1:0]     pc_d;
    logic [PW-1:0]     pad_q, pad_d;
    logic [INST_W-1:0] inst_d;
    logic              valid_d;
    logic              we_c;
    logic [AW-1:0]     raddr_c;
    logic [INST_W-1:0] rdata_c;
    logic              last_c;
    logic              pad_end_c;

    prog_ram #(
        .INST_W (INST_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (we_c),
        .waddr (count[AW-1:0]),
        .wdata (ld_data),
        .raddr (raddr_c),
        .rdata (rdata_c)
    );

    assign ld_full   = (count == CW'(DEPTH));
    assign busy      = (state_q == RUN) || (state_q == PAD);
    assign done      = (state_q == DONE);
    assign last_c    = ({1'b0, pc_tag} == (count - CW'(1)));
    assign pad_end_c = ((32'(pad_q) + 32'd1) >= NOP_PAD);

    // State register plus the issue datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            count      <= '0;
            pc_tag     <= '0;
            pad_q      <= '0;
            inst       <= NOP_WORD;
            inst_valid <= 1'b0;
        end else begin
            state_q    <= state_d;
            count      <= count_d;
            pc_tag     <= pc_d;
            pad_q      <= pad_d;
            inst       <= inst_d;
            inst_valid <= valid_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        count_d = count;
        pc_d    = pc_tag;
        pad_d   = pad_q;
        inst_d  = inst;
        valid_d = inst_valid;
        we_c    = 1'b0;
        raddr_c = '0;

        case (state_q)
            IDLE, DONE: begin
                if (clr) begin
                    state_d = IDLE;
                    count_d = '0;
                    pc_d    = '0;
                    inst_d  = NOP_WORD;
                    valid_d = 1'b0;
                end else if (start && (count != '0)) begin
                    state_d = RUN;
                    pc_d    = '0;
                    raddr_c = '0;
                    inst_d  = rdata_c;
                    valid_d = 1'b1;
                end else if ((state_q == IDLE) && ld_en && !ld_full) begin
                    we_c    = 1'b1;
                    count_d = count + CW'(1);
                end
            end

            RUN: begin
                if (halt) begin
                    state_d = DONE;
                    pc_d    = '0;
                    inst_d  = NOP_WORD;
                    valid_d = 1'b0;
                end else if (!stall) begin
                    if (last_c) begin
                        state_d = (NOP_PAD == 0) ? DONE : PAD;
                        pad_d   = '0;
                        pc_d    = '0;
                        inst_d  = NOP_WORD;
                        valid_d = 1'b0;
                    end else begin
                        pc_d    = pc_tag + AW'(1);
                        raddr_c = pc_tag + AW'(1);
                        inst_d  = rdata_c;
                        valid_d = 1'b1;
                    end
                end
            end

            PAD: begin
                inst_d  = NOP_WORD;
                valid_d = 1'b0;
                if (halt) begin
                    state_d = DONE;
                end else if (!stall) begin
                    if (pad_end_c) begin
                        state_d = DONE;
                    end else begin
                        pad_d = pad_q + PW'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_prog_feeder.sv
// Self-checking bench for prog_feeder: vector table, directed corner sequences, random vs. model.
module tb_prog_feeder;

    logic        clk;
    logic        rst;
    logic        ld_en;
    logic [31:0] ld_data;
    logic        ld_full;
    logic        start;
    logic        clr;
    logic        stall;
    logic        halt;
    logic [31:0] inst;
    logic        inst_valid;
    logic [3:0]  pc_tag;
    logic [4:0]  count;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    prog_feeder dut (
        .clk        (clk),
        .rst        (rst),
        .ld_en      (ld_en),
        .ld_data    (ld_data),
        .ld_full    (ld_full),
        .start      (start),
        .clr        (clr),
        .stall      (stall),
        .halt       (halt),
        .inst       (inst),
        .inst_valid (inst_valid),
        .pc_tag     (pc_tag),
        .count      (count),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference model: program list plus an issue position over words then padding
    localparam int MDEPTH = 16;
    localparam int MPAD   = 4;
    logic [31:0] m_prog[$];
    int          m_pos;
    bit          m_run;
    bit          m_fin;

    task automatic model_reset();
        m_prog.delete();
        m_pos = 0;
        m_run = 0;
        m_fin = 0;
    endtask

    task automatic model_step();
        if (m_run) begin
            if (halt) begin
                m_run = 0;
                m_fin = 1;
            end else if (!stall) begin
                m_pos++;
                if (m_pos >= m_prog.size() + MPAD) begin
                    m_run = 0;
                    m_fin = 1;
                end
            end
        end else begin
            if (clr) begin
                m_prog.delete();
                m_fin = 0;
            end else if (start && m_prog.size() > 0) begin
                m_run = 1;
                m_fin = 0;
                m_pos = 0;
            end else if (!m_fin && ld_en && m_prog.size() < MDEPTH) begin
                m_prog.push_back(ld_data);
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        bit          ev;
        logic [31:0] ei;
        int          et;
        ev = m_run && (m_pos < m_prog.size());
        ei = ev ? m_prog[m_pos] : 32'h0;
        et = ev ? m_pos : 0;
        chk({tag, ".inst"}, 64'(inst), 64'(ei));
        chk({tag, ".valid"}, 64'(inst_valid), 64'(ev));
        chk({tag, ".pc_tag"}, 64'(pc_tag), 64'(et));
        chk({tag, ".count"}, 64'(count), 64'(m_prog.size()));
        chk({tag, ".busy"}, 64'(busy), 64'(m_run));
        chk({tag, ".done"}, 64'(done), 64'(m_fin));
        chk({tag, ".ld_full"}, 64'(ld_full), 64'(m_prog.size() == MDEPTH));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        ld_en = 0; ld_data = 0; start = 0; clr = 0; stall = 0; halt = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        rst = 0;
        model_reset();
        #2;
        chk("rst.inst", 64'(inst), 64'h0);
        chk("rst.valid", 64'(inst_valid), 64'h0);
        chk("rst.count", 64'(count), 64'h0);
        chk("rst.busy_done", 64'({busy, done, ld_full, pc_tag}), 64'h0);
        @(negedge clk);
        rst = 1;
    endtask

    task automatic load(input logic [31:0] w);
        ld_en = 1;
        ld_data = w;
        tick();
        ld_en = 0;
        check_model("load");
    endtask

    typedef struct {
        logic        ld_en;
        logic [31:0] ld_data;
        logic        start;
        logic        clr;
        logic        stall;
        logic        halt;
        logic [31:0] e_inst;
        logic        e_valid;
        logic [3:0]  e_tag;
        logic [4:0]  e_count;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    function automatic vec_t mkv(logic l, logic [31:0] d, logic s, logic c,
                                 logic [31:0] ei, logic ev, logic [3:0] et,
                                 logic [4:0] ec, logic eb, logic ed);
        vec_t v;
        v.ld_en = l; v.ld_data = d; v.start = s; v.clr = c; v.stall = 0; v.halt = 0;
        v.e_inst = ei; v.e_valid = ev; v.e_tag = et; v.e_count = ec; v.e_busy = eb; v.e_done = ed;
        return v;
    endfunction

    vec_t vt[$];

    initial begin
        int          k;
        int          issued;
        bit          seen17;
        logic [31:0] w;
        logic [31:0] prog5 [5];

        rst = 0;
        idle_inputs();
        model_reset();
        #3;
        chk("por.outputs", 64'({inst, inst_valid, pc_tag, busy, done, ld_full}), 64'h0);
        chk("por.count", 64'(count), 64'h0);
        @(negedge clk);
        rst = 1;

        // Basic program, replay from DONE, then clr+start together
        vt.push_back(mkv(1, 32'h8080_0190, 0, 0, 32'h0, 0, 0, 1, 0, 0));
        vt.push_back(mkv(1, 32'h8100_012C, 0, 0, 32'h0, 0, 0, 2, 0, 0));
        vt.push_back(mkv(1, 32'h0989_0000, 0, 0, 32'h0, 0, 0, 3, 0, 0));
        vt.push_back(mkv(0, 0, 1, 0, 32'h8080_0190, 1, 0, 3, 1, 0));
        vt.push_back(mkv(0, 0, 0, 0, 32'h8100_012C, 1, 1, 3, 1, 0));
        vt.push_back(mkv(0, 0, 0, 0, 32'h0989_0000, 1, 2, 3, 1, 0));
        for (int i = 0; i < 4; i++) vt.push_back(mkv(0, 0, 0, 0, 32'h0, 0, 0, 3, 1, 0));
        vt.push_back(mkv(0, 0, 0, 0, 32'h0, 0, 0, 3, 0, 1));
        vt.push_back(mkv(1, 32'hDEAD_BEEF, 0, 0, 32'h0, 0, 0, 3, 0, 1));
        vt.push_back(mkv(0, 0, 1, 0, 32'h8080_0190, 1, 0, 3, 1, 0));
        vt.push_back(mkv(0, 0, 1, 1, 32'h8100_012C, 1, 1, 3, 1, 0));
        vt.push_back(mkv(0, 0, 0, 0, 32'h0989_0000, 1, 2, 3, 1, 0));
        for (int i = 0; i < 4; i++) vt.push_back(mkv(0, 0, 0, 0, 32'h0, 0, 0, 3, 1, 0));
        vt.push_back(mkv(0, 0, 0, 0, 32'h0, 0, 0, 3, 0, 1));
        vt.push_back(mkv(0, 0, 1, 1, 32'h0, 0, 0, 0, 0, 0));
        vt.push_back(mkv(1, 32'h1234_5678, 1, 0, 32'h0, 0, 0, 1, 0, 0));

        foreach (vt[i]) begin
            ld_en = vt[i].ld_en; ld_data = vt[i].ld_data; start = vt[i].start;
            clr = vt[i].clr; stall = vt[i].stall; halt = vt[i].halt;
            tick();
            chk($sformatf("vec%0d.inst", i), 64'(inst), 64'(vt[i].e_inst));
            chk($sformatf("vec%0d.valid_tag", i), 64'({inst_valid, pc_tag}), 64'({vt[i].e_valid, vt[i].e_tag}));
            chk($sformatf("vec%0d.count", i), 64'(count), 64'(vt[i].e_count));
            chk($sformatf("vec%0d.busy_done", i), 64'({busy, done}), 64'({vt[i].e_busy, vt[i].e_done}));
        end
        idle_inputs();

        // Stall for two cycles while pc_tag=1
        do_reset();
        load(32'h8080_0190); load(32'h8100_012C); load(32'h0989_0000);
        start = 1; tick(); start = 0; k = 1;
        tick(); k++;
        chk("stall.w1a", 64'({inst, pc_tag}), {28'h0, 32'h8100_012C, 4'd1});
        stall = 1; tick(); k++;
        chk("stall.w1b", 64'({inst, pc_tag, inst_valid}), {27'h0, 32'h8100_012C, 4'd1, 1'b1});
        tick(); k++;
        chk("stall.w1c", 64'({inst, pc_tag, inst_valid}), {27'h0, 32'h8100_012C, 4'd1, 1'b1});
        stall = 0; tick(); k++;
        chk("stall.w2", 64'({inst, pc_tag}), {28'h0, 32'h0989_0000, 4'd2});
        while (!done && k < 50) begin
            tick(); k++;
            check_model("stall.run");
        end
        chk("stall.done_latency", 64'(k), 64'd10);

        // Overfill: 17 writes into 16 entries
        do_reset();
        for (int i = 0; i < 17; i++) begin
            ld_en = 1; ld_data = 32'hA000_0000 + 32'(i);
            tick();
        end
        ld_en = 0;
        chk("full.count", 64'(count), 64'd16);
        chk("full.ld_full", 64'(ld_full), 64'd1);
        check_model("full");
        start = 1; tick(); start = 0;
        issued = 0; seen17 = 0; k = 0;
        while (!done && k < 100) begin
            if (inst_valid) begin
                issued++;
                if (inst == 32'hA000_0010) seen17 = 1;
            end
            check_model("full.run");
            tick(); k++;
        end
        chk("full.issued", 64'(issued), 64'd16);
        chk("full.word17_seen", 64'(seen17), 64'd0);
        chk("full.done", 64'(done), 64'd1);

        // Halt while pc_tag=1 in a 5-word program
        do_reset();
        for (int i = 0; i < 5; i++) begin
            prog5[i] = $urandom;
            load(prog5[i]);
        end
        start = 1; tick(); start = 0;
        chk("halt.w0", 64'(inst), 64'(prog5[0]));
        tick();
        chk("halt.tag1", 64'({inst, pc_tag}), {28'h0, prog5[1], 4'd1});
        halt = 1; stall = 1; tick(); halt = 0; stall = 0;
        chk("halt.done", 64'({done, busy, inst_valid}), 64'b100);
        chk("halt.inst", 64'(inst), 64'h0);
        tick();
        chk("halt.stays_done", 64'({done, busy}), 64'b10);
        check_model("halt");

        // Asynchronous reset in the middle of issue
        do_reset();
        load(32'h1111_1111); load(32'h2222_2222); load(32'h3333_3333);
        start = 1; tick(); start = 0;
        tick();
        chk("arst.pre", 64'({inst_valid, busy}), 64'b11);
        #2 rst = 0;
        #1;
        chk("arst.inst", 64'(inst), 64'h0);
        chk("arst.flags", 64'({inst_valid, pc_tag, busy, done, ld_full}), 64'h0);
        chk("arst.count", 64'(count), 64'h0);
        model_reset();
        @(negedge clk);
        rst = 1;
        start = 1; tick(); start = 0;
        chk("arst.start_ignored", 64'({inst_valid, busy, done, count}), 64'h0);
        tick();
        check_model("arst.after");

        // Random stimulus against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            ld_en   = ($urandom_range(0, 99) < 45);
            ld_data = $urandom;
            start   = ($urandom_range(0, 99) < 8);
            clr     = ($urandom_range(0, 99) < 3);
            stall   = ($urandom_range(0, 99) < 25);
            halt    = ($urandom_range(0, 99) < 3);
            tick();
            check_model("rand");
        end
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
